// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the instruction/data SRAM port arbiter: FSM states,
// port ownership and the debug view of arbiter state.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arbState_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } arbOwner_e;

  typedef struct packed {
    arbState_e state;
    arbOwner_e owner;
    arbOwner_e lastGrant;
  } arbDbg_t;

  localparam int DEFAULT_LATENCY = 1;

  // Counter must hold LATENCY-1; keep at least one bit when LATENCY is 1.
  function automatic int cntWidth(input int latency);
    return (latency > 1) ? $clog2(latency) : 1;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// CPU fetch/data ports and SRAM port of the arbiter, bundled as one interface.
// Handshake: a req is held (with stable fields) until its addr_ok is seen high
// in the same cycle; that cycle is the transfer. Completion is the single-cycle
// *_data_ok pulse, with rdata valid then and held until the next load completes.
interface sram_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            inst_req;
  logic [AW-1:0]   inst_addr;
  logic            inst_addr_ok;
  logic [DW-1:0]   inst_rdata;
  logic            inst_data_ok;

  logic            data_req;
  logic            data_wr;
  logic [DW/8-1:0] data_wen;
  logic [AW-1:0]   data_addr;
  logic [DW-1:0]   data_wdata;
  logic            data_addr_ok;
  logic [DW-1:0]   data_rdata;
  logic            data_data_ok;

  logic            mem_en;
  logic [DW/8-1:0] mem_wen;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  logic            busy;

  modport slave (
    input  inst_req, inst_addr, data_req, data_wr, data_wen, data_addr,
           data_wdata, mem_rdata,
    output inst_addr_ok, inst_rdata, inst_data_ok, data_addr_ok, data_rdata,
           data_data_ok, mem_en, mem_wen, mem_addr, mem_wdata, busy
  );

  modport master (
    output inst_req, inst_addr, data_req, data_wr, data_wen, data_addr,
           data_wdata, mem_rdata,
    input  inst_addr_ok, inst_rdata, inst_data_ok, data_addr_ok, data_rdata,
           data_data_ok, mem_en, mem_wen, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/sram_port_arbiter_rr_grant2.sv
// Two-requester round-robin picker: a tie goes to the port that did not win
// last time. Only one grant per enabled cycle.
module rr_grant2
  import arb_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      en,
  input  logic      reqInst,
  input  logic      reqData,
  output logic      grantInst,
  output logic      grantData,
  output arbOwner_e lastGrant
);

  always_comb begin
    grantInst = 1'b0;
    grantData = 1'b0;
    if (en) begin
      if (reqInst && reqData) begin
        if (lastGrant == OWN_INST) grantData = 1'b1;
        else                       grantInst = 1'b1;
      end else begin
        grantInst = reqInst;
        grantData = reqData;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           lastGrant <= OWN_INST;
    else if (grantInst) lastGrant <= OWN_INST;
    else if (grantData) lastGrant <= OWN_DATA;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-ported synchronous SRAM between the fetch and data ports:
// one transaction at a time, IDLE -> ISSUE -> WAIT (LATENCY cycles) -> RESP.
module sram_port_arbiter
  import arb_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic       clk,
  input  logic       rst,
  sram_arb_if.slave  bus,
  output arbDbg_t    dbg
);

  localparam int            CW       = cntWidth(LATENCY);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  arbState_e       state, stateNext;
  arbOwner_e       owner, lastGrant;
  logic [CW-1:0]   cnt;
  logic            capWr;
  logic [AW-1:0]   capAddr;
  logic [DW/8-1:0] capWen;
  logic [DW-1:0]   capWdata;
  logic [DW-1:0]   instRdata, dataRdata;
  logic            grantInst, grantData;

  rr_grant2 u_grant (
    .clk       (clk),
    .rst       (rst),
    .en        (state == IDLE),
    .reqInst   (bus.inst_req),
    .reqData   (bus.data_req),
    .grantInst (grantInst),
    .grantData (grantData),
    .lastGrant (lastGrant)
  );

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (grantInst || grantData) stateNext = ISSUE;
      ISSUE:   stateNext = WAIT;
      WAIT:    if (cnt == '0) stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= OWN_INST;
      cnt       <= '0;
      capWr     <= 1'b0;
      capAddr   <= '0;
      capWen    <= '0;
      capWdata  <= '0;
      instRdata <= '0;
      dataRdata <= '0;
    end else begin
      state <= stateNext;
      // Fetches never write; byte enables are only kept for stores.
      if (grantInst) begin
        owner    <= OWN_INST;
        capWr    <= 1'b0;
        capAddr  <= bus.inst_addr;
        capWen   <= '0;
        capWdata <= '0;
      end else if (grantData) begin
        owner    <= OWN_DATA;
        capWr    <= bus.data_wr;
        capAddr  <= bus.data_addr;
        capWen   <= bus.data_wr ? bus.data_wen : '0;
        capWdata <= bus.data_wdata;
      end
      if (state == ISSUE)                  cnt <= CNT_LOAD;
      else if (state == WAIT && cnt != '0) cnt <= cnt - CW'(1);
      if (state == WAIT && cnt == '0 && !capWr) begin
        if (owner == OWN_INST) instRdata <= bus.mem_rdata;
        else                   dataRdata <= bus.mem_rdata;
      end
    end
  end

  assign bus.inst_addr_ok = grantInst;
  assign bus.data_addr_ok = grantData;
  assign bus.mem_en       = (state == ISSUE);
  assign bus.mem_wen      = (state == ISSUE) ? capWen : '0;
  assign bus.mem_addr     = capAddr;
  assign bus.mem_wdata    = capWdata;
  assign bus.inst_data_ok = (state == RESP) && (owner == OWN_INST);
  assign bus.data_data_ok = (state == RESP) && (owner == OWN_DATA);
  assign bus.inst_rdata   = instRdata;
  assign bus.data_rdata   = dataRdata;
  assign bus.busy         = (state != IDLE);

  assign dbg = '{state: state, owner: owner, lastGrant: lastGrant};

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: three instances (LATENCY 1, 3, 15) driven by
// directed scenarios and a randomized run against a transaction-level model.
module tb_sram_port_arbiter;
  import arb_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int WB   = DW / 8;
  localparam int NDUT = 3;

  function automatic int latOf(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 15;
    endcase
  endfunction

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- per-instance stimulus and observation ----------------
  logic          instReq   [NDUT];
  logic [AW-1:0] instAddr  [NDUT];
  logic          dataReq   [NDUT];
  logic          dataWr    [NDUT];
  logic [WB-1:0] dataWen   [NDUT];
  logic [AW-1:0] dataAddr  [NDUT];
  logic [DW-1:0] dataWdata [NDUT];
  logic [DW-1:0] memRdata  [NDUT];

  logic          instAddrOk [NDUT];
  logic [DW-1:0] instRdata  [NDUT];
  logic          instDataOk [NDUT];
  logic          dataAddrOk [NDUT];
  logic [DW-1:0] dataRdata  [NDUT];
  logic          dataDataOk [NDUT];
  logic          memEn      [NDUT];
  logic [WB-1:0] memWen     [NDUT];
  logic [AW-1:0] memAddr    [NDUT];
  logic [DW-1:0] memWdata   [NDUT];
  logic          busy       [NDUT];
  arbDbg_t       dbg        [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : gDut
    sram_arb_if #(.AW(AW), .DW(DW)) bus ();

    assign bus.inst_req   = instReq[g];
    assign bus.inst_addr  = instAddr[g];
    assign bus.data_req   = dataReq[g];
    assign bus.data_wr    = dataWr[g];
    assign bus.data_wen   = dataWen[g];
    assign bus.data_addr  = dataAddr[g];
    assign bus.data_wdata = dataWdata[g];
    assign bus.mem_rdata  = memRdata[g];

    assign instAddrOk[g] = bus.inst_addr_ok;
    assign instRdata[g]  = bus.inst_rdata;
    assign instDataOk[g] = bus.inst_data_ok;
    assign dataAddrOk[g] = bus.data_addr_ok;
    assign dataRdata[g]  = bus.data_rdata;
    assign dataDataOk[g] = bus.data_data_ok;
    assign memEn[g]      = bus.mem_en;
    assign memWen[g]     = bus.mem_wen;
    assign memAddr[g]    = bus.mem_addr;
    assign memWdata[g]   = bus.mem_wdata;
    assign busy[g]       = bus.busy;

    sram_port_arbiter #(.LATENCY(latOf(g)), .AW(AW), .DW(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus),
      .dbg (dbg[g])
    );
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    for (int k = 0; k < NDUT; k++) begin
      instReq[k]   = 1'b0;
      instAddr[k]  = '0;
      dataReq[k]   = 1'b0;
      dataWr[k]    = 1'b0;
      dataWen[k]   = '0;
      dataAddr[k]  = '0;
      dataWdata[k] = '0;
      memRdata[k]  = '0;
    end
  endtask

  task automatic doReset();
    tick();
    rst = 1'b0;
    idleInputs();
    tick();
    rst = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    idleInputs();
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if ({busy[k], memEn[k], instAddrOk[k], dataAddrOk[k], instDataOk[k], dataDataOk[k]} !== 6'b0) begin
        failures++;
        $display("FAIL reset_ctrl k=%0d got=%b exp=000000", k,
                 {busy[k], memEn[k], instAddrOk[k], dataAddrOk[k], instDataOk[k], dataDataOk[k]});
      end
      checks++;
      if ({memWen[k], memAddr[k], memWdata[k]} !== '0) begin
        failures++;
        $display("FAIL reset_mem k=%0d got wen=%h addr=%h wdata=%h exp=0", k, memWen[k], memAddr[k], memWdata[k]);
      end
      checks++;
      if ({instRdata[k], dataRdata[k]} !== '0) begin
        failures++;
        $display("FAIL reset_rdata k=%0d got inst=%h data=%h exp=0", k, instRdata[k], dataRdata[k]);
      end
      checks++;
      if (dbg[k].state !== IDLE || dbg[k].lastGrant !== OWN_INST) begin
        failures++;
        $display("FAIL reset_state k=%0d got state=%0d last=%0d exp state=0 last=0", k, dbg[k].state, dbg[k].lastGrant);
      end
    end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_single_fetch();
    int k = 0;
    tick();
    instReq[k]  = 1'b1;
    instAddr[k] = 32'hBFC0_0000;
    memRdata[k] = $urandom();
    @(negedge clk);
    checks++;
    if ({instAddrOk[k], dataAddrOk[k]} !== 2'b10) begin
      failures++;
      $display("FAIL fetch_addr_ok got=%b exp=10", {instAddrOk[k], dataAddrOk[k]});
    end
    tick();
    instReq[k]  = 1'b0;
    instAddr[k] = $urandom();
    memRdata[k] = $urandom();
    @(negedge clk);
    checks++;
    if ({memEn[k], memWen[k]} !== 5'b1_0000) begin
      failures++;
      $display("FAIL fetch_issue got en=%b wen=%b exp en=1 wen=0000", memEn[k], memWen[k]);
    end
    checks++;
    if (memAddr[k] !== 32'hBFC0_0000) begin
      failures++;
      $display("FAIL fetch_mem_addr got=%h exp=bfc00000", memAddr[k]);
    end
    tick();
    memRdata[k] = 32'h3C1D_8000;
    @(negedge clk);
    checks++;
    if ({instDataOk[k], memEn[k]} !== 2'b00) begin
      failures++;
      $display("FAIL fetch_wait got ok=%b en=%b exp 0 0", instDataOk[k], memEn[k]);
    end
    tick();
    memRdata[k] = $urandom();
    @(negedge clk);
    checks++;
    if ({instDataOk[k], dataDataOk[k]} !== 2'b10) begin
      failures++;
      $display("FAIL fetch_data_ok got=%b exp=10", {instDataOk[k], dataDataOk[k]});
    end
    checks++;
    if (instRdata[k] !== 32'h3C1D_8000) begin
      failures++;
      $display("FAIL fetch_rdata got=%h exp=3c1d8000", instRdata[k]);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({instDataOk[k], busy[k]} !== 2'b00 || instRdata[k] !== 32'h3C1D_8000) begin
      failures++;
      $display("FAIL fetch_after got ok=%b busy=%b rdata=%h exp 0 0 3c1d8000", instDataOk[k], busy[k], instRdata[k]);
    end
  endtask

  task automatic test_store();
    int k = 1;
    int lat = latOf(1);
    tick();
    dataReq[k]   = 1'b1;
    dataWr[k]    = 1'b1;
    dataWen[k]   = 4'b0011;
    dataAddr[k]  = 32'h0000_0010;
    dataWdata[k] = 32'h0000_BEEF;
    memRdata[k]  = $urandom();
    @(negedge clk);
    checks++;
    if (dataAddrOk[k] !== 1'b1) begin
      failures++;
      $display("FAIL store_addr_ok got=%b exp=1", dataAddrOk[k]);
    end
    for (int c = 1; c <= lat + 3; c++) begin
      tick();
      if (c == 1) begin
        dataReq[k]   = 1'b0;
        dataWen[k]   = 4'b1111;
        dataWdata[k] = $urandom();
      end
      memRdata[k] = $urandom();
      @(negedge clk);
      checks++;
      if (memEn[k] !== (c == 1)) begin
        failures++;
        $display("FAIL store_mem_en c=%0d got=%b exp=%b", c, memEn[k], (c == 1));
      end
      if (c == 1) begin
        checks++;
        if ({memWen[k], memWdata[k], memAddr[k]} !== {4'b0011, 32'h0000_BEEF, 32'h0000_0010}) begin
          failures++;
          $display("FAIL store_issue got wen=%b wdata=%h addr=%h exp 0011 0000beef 00000010", memWen[k], memWdata[k], memAddr[k]);
        end
      end
      checks++;
      if (dataDataOk[k] !== (c == lat + 2)) begin
        failures++;
        $display("FAIL store_data_ok c=%0d got=%b exp=%b", c, dataDataOk[k], (c == lat + 2));
      end
    end
    checks++;
    if (dataRdata[k] !== '0) begin
      failures++;
      $display("FAIL store_rdata got=%h exp=0", dataRdata[k]);
    end
  endtask

  task automatic test_tie();
    int k = 0;
    int grants = 0;
    int oks = 0;
    logic expOwn = 1'b1;
    logic [0:0] expQ[$];
    doReset();
    tick();
    instReq[k]  = 1'b1;
    instAddr[k] = 32'h0000_1000;
    dataReq[k]  = 1'b1;
    dataWr[k]   = 1'b0;
    dataAddr[k] = 32'h0000_2000;
    for (int c = 0; c < 80 && !(grants >= 6 && oks >= 6); c++) begin
      if (c > 0) tick();
      memRdata[k] = $urandom();
      @(negedge clk);
      checks++;
      if ((instAddrOk[k] && dataAddrOk[k]) !== 1'b0 || (instDataOk[k] && dataDataOk[k]) !== 1'b0) begin
        failures++;
        $display("FAIL tie_exclusive c=%0d got aok=%b%b dok=%b%b", c, instAddrOk[k], dataAddrOk[k], instDataOk[k], dataDataOk[k]);
      end
      if (instAddrOk[k] || dataAddrOk[k]) begin
        checks++;
        if (dataAddrOk[k] !== expOwn) begin
          failures++;
          $display("FAIL tie_grant n=%0d got data=%b exp data=%b", grants, dataAddrOk[k], expOwn);
        end
        expQ.push_back(expOwn);
        expOwn = ~expOwn;
        grants++;
      end
      if (instDataOk[k] || dataDataOk[k]) begin
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("FAIL tie_route n=%0d got data_ok with no accepted transaction", oks);
        end else begin
          if (dataDataOk[k] !== expQ[0]) begin
            failures++;
            $display("FAIL tie_route n=%0d got data=%b exp data=%b", oks, dataDataOk[k], expQ[0]);
          end
          void'(expQ.pop_front());
        end
        oks++;
      end
    end
    checks++;
    if (grants < 6 || oks < 6) begin
      failures++;
      $display("FAIL tie_timeout got grants=%0d oks=%0d exp 6 6", grants, oks);
    end
    tick();
    idleInputs();
  endtask

  task automatic test_busy_request();
    int k = 1;
    int lat = latOf(1);
    int t2 = lat + 3;
    tick();
    dataReq[k]  = 1'b1;
    dataWr[k]   = 1'b0;
    dataAddr[k] = 32'h0000_0040;
    @(negedge clk);
    checks++;
    if (dataAddrOk[k] !== 1'b1) begin
      failures++;
      $display("FAIL busy_first_ok got=%b exp=1", dataAddrOk[k]);
    end
    for (int c = 1; c <= 2 * t2; c++) begin
      tick();
      if (c == 1) dataReq[k] = 1'b0;
      if (c == 2) begin
        instReq[k]  = 1'b1;
        instAddr[k] = 32'h0000_0080;
      end
      if (c == t2 + 1) instReq[k] = 1'b0;
      memRdata[k] = $urandom();
      @(negedge clk);
      checks++;
      if (instAddrOk[k] !== (c == t2)) begin
        failures++;
        $display("FAIL busy_inst_ok c=%0d got=%b exp=%b", c, instAddrOk[k], (c == t2));
      end
      checks++;
      if (busy[k] !== !(c == t2 || c == 2 * t2)) begin
        failures++;
        $display("FAIL busy_flag c=%0d got=%b exp=%b", c, busy[k], !(c == t2 || c == 2 * t2));
      end
      checks++;
      if ({dataDataOk[k], instDataOk[k]} !== {(c == lat + 2), (c == t2 + lat + 2)}) begin
        failures++;
        $display("FAIL busy_data_ok c=%0d got=%b%b exp=%b%b", c, dataDataOk[k], instDataOk[k], (c == lat + 2), (c == t2 + lat + 2));
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int k = 2;
    int lat = latOf(2);
    tick();
    dataReq[k]  = 1'b1;
    dataWr[k]   = 1'b0;
    dataAddr[k] = 32'h0000_0100;
    @(negedge clk);
    checks++;
    if (dataAddrOk[k] !== 1'b1) begin
      failures++;
      $display("FAIL rstw_first_ok got=%b exp=1", dataAddrOk[k]);
    end
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) dataReq[k] = 1'b0;
      memRdata[k] = $urandom();
      @(negedge clk);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy[k], dataDataOk[k]} !== 2'b00 || dbg[k].state !== IDLE) begin
      failures++;
      $display("FAIL rstw_drop got busy=%b ok=%b state=%0d exp 0 0 0", busy[k], dataDataOk[k], dbg[k].state);
    end
    tick();
    rst          = 1'b1;
    dataReq[k]   = 1'b1;
    dataWr[k]    = 1'b1;
    dataWen[k]   = 4'hF;
    dataAddr[k]  = 32'h0000_0200;
    dataWdata[k] = $urandom();
    @(negedge clk);
    checks++;
    if (dataAddrOk[k] !== 1'b1) begin
      failures++;
      $display("FAIL rstw_new_ok got=%b exp=1", dataAddrOk[k]);
    end
    for (int c = 1; c <= lat + 3; c++) begin
      tick();
      if (c == 1) dataReq[k] = 1'b0;
      memRdata[k] = $urandom();
      @(negedge clk);
      checks++;
      if ({dataDataOk[k], instDataOk[k]} !== {(c == lat + 2), 1'b0}) begin
        failures++;
        $display("FAIL rstw_data_ok c=%0d got=%b%b exp=%b0", c, dataDataOk[k], instDataOk[k], (c == lat + 2));
      end
    end
    checks++;
    if (dataRdata[k] !== '0) begin
      failures++;
      $display("FAIL rstw_rdata got=%h exp=0", dataRdata[k]);
    end
  endtask

  task automatic test_latency15();
    int k = 2;
    int lat = latOf(2);
    int nEn = 0;
    logic [DW-1:0] word = $urandom();
    tick();
    dataReq[k]  = 1'b1;
    dataWr[k]   = 1'b0;
    dataAddr[k] = 32'h0000_0300;
    @(negedge clk);
    checks++;
    if (dataAddrOk[k] !== 1'b1) begin
      failures++;
      $display("FAIL lat15_addr_ok got=%b exp=1", dataAddrOk[k]);
    end
    for (int c = 1; c <= lat + 3; c++) begin
      tick();
      if (c == 1) dataReq[k] = 1'b0;
      memRdata[k] = (c == lat + 1) ? word : ~word;
      @(negedge clk);
      if (memEn[k]) nEn++;
      checks++;
      if (dataDataOk[k] !== (c == lat + 2)) begin
        failures++;
        $display("FAIL lat15_data_ok c=%0d got=%b exp=%b", c, dataDataOk[k], (c == lat + 2));
      end
      checks++;
      if (busy[k] !== (c <= lat + 2)) begin
        failures++;
        $display("FAIL lat15_busy c=%0d got=%b exp=%b", c, busy[k], (c <= lat + 2));
      end
      if (c == lat + 2) begin
        checks++;
        if (dataRdata[k] !== word) begin
          failures++;
          $display("FAIL lat15_rdata got=%h exp=%h", dataRdata[k], word);
        end
      end
    end
    checks++;
    if (nEn != 1) begin
      failures++;
      $display("FAIL lat15_mem_en_count got=%0d exp=1", nEn);
    end
  endtask

  // Transaction-level model: a transaction accepted in cycle T issues at T+1,
  // samples mem_rdata at T+LATENCY+1 and completes at T+LATENCY+2.
  task automatic test_random(input int k, input int ncyc);
    int lat = latOf(k);
    bit act = 1'b0;
    int ph = 0;
    bit own = 1'b0;
    bit lastG = 1'b0;
    bit cWr = 1'b0;
    logic [AW-1:0] cAddr = '0;
    logic [WB-1:0] cWen = '0;
    logic [DW-1:0] cWdata = '0;
    logic [DW-1:0] mInst = '0;
    logic [DW-1:0] mData = '0;
    bit iAcc = 1'b0;
    bit dAcc = 1'b0;
    bit eIA, eDA, eEn, eIOk, eDOk;
    doReset();
    for (int c = 0; c < ncyc; c++) begin
      tick();
      if (iAcc) instReq[k] = 1'b0;
      else if (instReq[k] && $urandom_range(0, 9) == 0) instReq[k] = 1'b0;
      else if (!instReq[k] && $urandom_range(0, 9) < 4) begin
        instReq[k]  = 1'b1;
        instAddr[k] = $urandom();
      end
      if (dAcc) dataReq[k] = 1'b0;
      else if (dataReq[k] && $urandom_range(0, 9) == 0) dataReq[k] = 1'b0;
      else if (!dataReq[k] && $urandom_range(0, 9) < 4) begin
        dataReq[k]   = 1'b1;
        dataWr[k]    = 1'($urandom_range(0, 1));
        dataWen[k]   = WB'($urandom_range(0, 15));
        dataAddr[k]  = $urandom();
        dataWdata[k] = $urandom();
      end
      memRdata[k] = $urandom();
      @(negedge clk);

      eIA  = !act && instReq[k] && (!dataReq[k] || lastG);
      eDA  = !act && dataReq[k] && (!instReq[k] || !lastG);
      eEn  = act && ph == 1;
      eIOk = act && ph == lat + 2 && !own;
      eDOk = act && ph == lat + 2 && own;

      checks++;
      if ({instAddrOk[k], dataAddrOk[k]} !== {eIA, eDA}) begin
        failures++;
        $display("FAIL rand_addr_ok k=%0d c=%0d got=%b%b exp=%b%b", k, c, instAddrOk[k], dataAddrOk[k], eIA, eDA);
      end
      checks++;
      if (busy[k] !== act) begin
        failures++;
        $display("FAIL rand_busy k=%0d c=%0d got=%b exp=%b", k, c, busy[k], act);
      end
      checks++;
      if ({memEn[k], memWen[k]} !== {eEn, (eEn ? cWen : WB'(0))}) begin
        failures++;
        $display("FAIL rand_mem_en k=%0d c=%0d got en=%b wen=%b exp en=%b wen=%b", k, c, memEn[k], memWen[k], eEn, (eEn ? cWen : WB'(0)));
      end
      if (eEn) begin
        checks++;
        if (memAddr[k] !== cAddr || (cWr && memWdata[k] !== cWdata)) begin
          failures++;
          $display("FAIL rand_mem_bus k=%0d c=%0d got addr=%h wdata=%h exp addr=%h wdata=%h", k, c, memAddr[k], memWdata[k], cAddr, cWdata);
        end
      end
      checks++;
      if ({instDataOk[k], dataDataOk[k]} !== {eIOk, eDOk}) begin
        failures++;
        $display("FAIL rand_data_ok k=%0d c=%0d got=%b%b exp=%b%b", k, c, instDataOk[k], dataDataOk[k], eIOk, eDOk);
      end
      checks++;
      if (instRdata[k] !== mInst || dataRdata[k] !== mData) begin
        failures++;
        $display("FAIL rand_rdata k=%0d c=%0d got inst=%h data=%h exp inst=%h data=%h", k, c, instRdata[k], dataRdata[k], mInst, mData);
      end

      iAcc = eIA;
      dAcc = eDA;
      if (act) begin
        if (ph == lat + 1 && !cWr) begin
          if (own) mData = memRdata[k];
          else     mInst = memRdata[k];
        end
        if (ph == lat + 2) act = 1'b0;
        else               ph++;
      end else if (eIA || eDA) begin
        act    = 1'b1;
        ph     = 1;
        own    = eDA;
        lastG  = eDA;
        cWr    = eDA && dataWr[k];
        cAddr  = eDA ? dataAddr[k] : instAddr[k];
        cWen   = cWr ? dataWen[k] : WB'(0);
        cWdata = dataWdata[k];
      end
    end
    tick();
    idleInputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idleInputs();
    test_reset();
    test_single_fetch();
    test_store();
    test_tie();
    test_busy_request();
    test_reset_mid_wait();
    test_latency15();
    for (int k = 0; k < NDUT; k++) test_random(k, 300);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-ported synchronous SRAM between the CPU instruction-fetch port and the CPU data port.
- Sits between the pipelined MIPS core and the memory: it serialises requests, counts fixed memory read latency, and returns a one-cycle completion pulse per transaction.
- The core's hazard unit consumes `busy` and the `*_data_ok` pulses to stall fetch and memory stages.

Parameters:
- LATENCY, 1, SRAM read latency in cycles from the `mem_en` cycle to the `mem_rdata` valid cycle; legal range 1..15.
- AW, 32, address width.
- DW, 32, data width; byte-enable width is DW/8.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- inst_req  in  1  fetch request; held until `inst_addr_ok`.
- inst_addr  in  AW  fetch address; stable while `inst_req`.
- inst_addr_ok  out  1  fetch request accepted this cycle.
- inst_rdata  out  DW  fetched word; valid with `inst_data_ok`, held afterwards.
- inst_data_ok  out  1  one-cycle fetch completion pulse.
- data_req  in  1  load/store request; held until `data_addr_ok`.
- data_wr  in  1  1 = store, 0 = load.
- data_wen  in  DW/8  store byte enables (ignored for loads).
- data_addr  in  AW  load/store address.
- data_wdata  in  DW  store data, already byte-lane aligned.
- data_addr_ok  out  1  data request accepted this cycle.
- data_rdata  out  DW  load word; valid with `data_data_ok`, held afterwards.
- data_data_ok  out  1  one-cycle load/store completion pulse.
- mem_en  out  1  SRAM access strobe.
- mem_wen  out  DW/8  SRAM byte write enables; all zero for reads.
- mem_addr  out  AW  SRAM address.
- mem_wdata  out  DW  SRAM write data.
- mem_rdata  in  DW  SRAM read data.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all outputs 0; `inst_rdata`/`data_rdata` = 0.
  - Latency counter = 0; `last_grant` = INST.
  - An in-flight transaction is dropped; no `data_ok` is produced for it.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: accepts at most one request per cycle; `addr_ok` is combinational from the req inputs and state.
  - Only one req high: grant it.
  - Both high: grant the port not in `last_grant`. So the first tie after reset goes to DATA, then grants alternate.
  - On grant: capture addr, wen, wdata, wr and the owner; update `last_grant`; go to ISSUE.
  - Captured wen is forced to 0 for loads and for INST.
- ISSUE, exactly 1 cycle:
  - `mem_en`=1; `mem_addr`/`mem_wen`/`mem_wdata` come from the captured registers.
  - Load counter with LATENCY-1; go to WAIT.
- WAIT:
  - cnt≠0: decrement.
  - cnt==0: if a read, capture `mem_rdata` into the owner's rdata register; go to RESP.
- RESP, 1 cycle: owner's `data_ok`=1; go to IDLE. No acceptance in RESP.
- Latency from accept cycle T to `data_ok` is T+LATENCY+2. Throughput is one transaction per LATENCY+3 cycles.
- Stores: `data_data_ok` has the same timing as loads; `data_rdata` is unchanged.
- Outside ISSUE: `mem_en`=0, `mem_wen`=0; `mem_addr`/`mem_wdata` hold their last value.
- A req dropped before `addr_ok` is legal: no transaction occurs.
- Req and addr_ok only in IDLE; a req raised while busy waits.
- The rdata registers of the non-owner port never change.
- At most one `*_data_ok` is high in any cycle; `inst_addr_ok` and `data_addr_ok` are never high together.
- The counter is sized to hold LATENCY-1 with no wrap. LATENCY=1 leaves cnt=0 on entry to WAIT, so WAIT lasts one cycle.

Decomposition:
- Shared package `arb_pkg`: state enum (IDLE, ISSUE, WAIT, RESP), owner encoding (OWN_INST=0, OWN_DATA=1), default LATENCY constant.
- One sub-module, `rr_grant2`: a combinational two-requester round-robin picker with the `last_grant` flop.
- The FSM, counter and capture registers stay in the top module.

Test Plan:
- Single fetch, LATENCY=1: `inst_req`=1, `inst_addr`=0xBFC00000 at cycle 0. Expect `inst_addr_ok`@0 and `mem_en`@1 with `mem_addr`=0xBFC00000, `mem_wen`=0. With `mem_rdata`=0x3C1D8000 @2, expect `inst_data_ok`@3 with `inst_rdata`=0x3C1D8000.
- Store, LATENCY=3: `data_wr`=1, `data_wen`=4'b0011, `data_addr`=0x10, `data_wdata`=0x0000BEEF. Expect one `mem_en` cycle with `mem_wen`=0011 and `mem_wdata`=0x0000BEEF; `data_data_ok` 5 cycles after accept; `data_rdata` unchanged.
- Simultaneous requests after reset, both held. Expect grant order DATA, INST, DATA, … and every `data_ok` pulse routed to the correct port.
- Request while busy: raise `inst_req` during the WAIT of a data load. Expect `inst_addr_ok` only in the first IDLE cycle after `data_data_ok`; `busy` low for exactly that one cycle.
- Reset mid-WAIT (rst=0 for 1 cycle). Expect immediate `busy`=0, no `data_ok` for the dropped transaction, and a new request accepted in the first cycle after reset release.
- LATENCY=15 load. Expect `data_data_ok` exactly 17 cycles after accept and only one `mem_en` cycle.
